// File: rtl/pmu_pkg.sv
// Shared constants and FSM state type for the PMU speed scheduler.
package pmu_pkg;

  localparam int DEF_N_REQ         = 4;
  localparam int DEF_VEC_W         = 8;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int CNT_W             = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } pmu_state_e;

endpackage

// File: rtl/pmu_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester found after
// 'pointer' (wrapping) wins. No state here; the pointer lives in the caller.
module pmu_rr_arbiter
  import pmu_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] pointer,
  output logic [N_REQ-1:0] grant,
  output logic             valid
);

  // Pick the set request with the smallest rotational distance past the pointer
  always_comb begin
    int best_d;
    int d;
    grant  = '0;
    valid  = 1'b0;
    best_d = N_REQ;
    d      = 0;
    for (int j = 0; j < N_REQ; j++) begin
      d = (j - int'(pointer) - 1 + 2 * N_REQ) % N_REQ;
      if (req[j] && (d < best_d)) begin
        best_d   = d;
        grant    = '0;
        grant[j] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmu_speed_scheduler.sv
// Serialises speed-change requests from several requesters onto a single
// power_manager change/change_vector interface, with a settle hold-off.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting; samples req and latches the round-robin winner
// ST_APPLY  | change strobe high for one cycle, change_vector already valid
// ST_SETTLE | hold-off of SETTLE_CYCLES cycles, counted down by cnt
// ST_DONE   | ack to winner, commit cur_vector, advance round-robin pointer
module pmu_speed_scheduler
  import pmu_pkg::*;
#(
  parameter int N_REQ         = DEF_N_REQ,
  parameter int VEC_W         = DEF_VEC_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*VEC_W-1:0] req_vector,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy,
  output logic                   change,
  output logic [VEC_W-1:0]       change_vector,
  output logic [VEC_W-1:0]       cur_vector
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  pmu_state_e       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] win_idx;
  logic [N_REQ-1:0] win_oh;
  logic [VEC_W-1:0] lat_vec;
  logic [CNT_W-1:0] cnt;

  logic [N_REQ-1:0] grant;
  logic             grant_valid;
  logic [PTR_W-1:0] sel_idx;
  logic [VEC_W-1:0] sel_vec;

  pmu_rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req     (req),
    .pointer (rr_ptr),
    .grant   (grant),
    .valid   (grant_valid)
  );

  // Mux the granted requester's vector and index out of the one-hot grant
  always_comb begin
    sel_vec = '0;
    sel_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_vec = req_vector[i*VEC_W +: VEC_W];
        sel_idx = PTR_W'(i);
      end
    end
  end

  // Sequencer: latch winner, strobe change, settle, then ack and commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      rr_ptr        <= PTR_W'(N_REQ - 1);
      win_idx       <= '0;
      win_oh        <= '0;
      lat_vec       <= '0;
      change_vector <= '0;
      cur_vector    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            win_idx <= sel_idx;
            win_oh  <= grant;
            lat_vec <= sel_vec;
            // Re-requesting the vector already applied skips the PM handshake
            if (sel_vec == cur_vector) begin
              state <= ST_DONE;
            end else begin
              state         <= ST_APPLY;
              change_vector <= sel_vec;
            end
          end
        end
        ST_APPLY: begin
          cnt   <= CNT_W'(SETTLE_CYCLES - 1);
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          cur_vector <= lat_vec;
          rr_ptr     <= win_idx;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decoded straight from registered state
  always_comb begin
    busy   = (state != ST_IDLE);
    change = (state == ST_APPLY);
    ack    = (state == ST_DONE) ? win_oh : '0;
  end

endmodule
